// File: rtl/add_mw_sequencer_pkg.sv
// Shared definitions for the multi-word sequential adder: FSM state encoding,
// byte width and the index-width helper used to size the byte counter.
// Imported by the interface, the byte adder and the sequencer top.
package add_mw_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte counter needs at least one bit even for single-byte operands.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/add_mw_sequencer_if.sv
// Request/response bundle between a requester and the multi-word adder.
// master = requester side, slave = sequencer side.
// in_sub exists only when ADD_SEQ_SUB_EN is defined.
interface add_mw_sequencer_if
    import add_mw_sequencer_pkg::*;
    #(parameter int WORDS = 4) ();

    localparam int W = BYTE_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef ADD_SEQ_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

`ifdef ADD_SEQ_SUB_EN
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );
`endif

endinterface

// File: rtl/add_mw_sequencer_add8.sv
// Shared 8-bit ripple-carry adder used as the narrow datapath of the sequencer.
// Latency: purely combinational.
// Backpressure: none; it simply follows its inputs.
module add_mw_sequencer_add8
    import add_mw_sequencer_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              carry_in,
    output logic [BYTE_W-1:0] sum,
    output logic              carry_out
);

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin : ripple
        logic c;
        sum = '0;
        c   = carry_in;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/add_mw_sequencer.sv
// Multi-word adder: adds two WORDS-byte operands one byte per cycle, LSB first, on one 8-bit adder.
// Latency: out_valid rises WORDS cycles after the accept edge; initiation interval WORDS+2.
// Backpressure: result held in DONE until out_ready; in_ready low while RUN/DONE (no queuing).
// Optional subtract support (in_sub port) is built when ADD_SEQ_SUB_EN is defined.
module add_mw_sequencer
    import add_mw_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    add_mw_sequencer_if.slave  bus
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic                           carry;
    logic [WORDS-1:0][BYTE_W-1:0]   a_r;
    logic [WORDS-1:0][BYTE_W-1:0]   b_r;
    logic [WORDS-1:0][BYTE_W-1:0]   sum_r;
    logic                           cout_r;
    logic                           valid_r;
    logic                           busy_r;
`ifdef ADD_SEQ_SUB_EN
    logic                           sub_r;
`endif

    logic [BYTE_W-1:0]              a_byte;
    logic [BYTE_W-1:0]              b_byte;
    logic [BYTE_W-1:0]              add_sum;
    logic                           add_cout;
    logic                           init_carry;

    // Ready is gated by rst so a request can never be accepted on a reset edge.
    assign bus.in_ready  = (state == ST_IDLE) & ~rst;
    assign bus.out_valid = valid_r;
    assign bus.out_sum   = sum_r;
    assign bus.out_cout  = cout_r;
    assign bus.busy      = busy_r;

    // Select the current operand bytes; subtraction feeds inverted B bytes.
    always_comb begin
        a_byte = a_r[idx];
        b_byte = b_r[idx];
`ifdef ADD_SEQ_SUB_EN
        if (sub_r) begin
            b_byte = ~b_r[idx];
        end
`endif
    end

    // Starting carry: forced to 1 for two's-complement subtraction, else the requester's cin.
    always_comb begin
`ifdef ADD_SEQ_SUB_EN
        init_carry = bus.in_sub ? 1'b1 : bus.in_cin;
`else
        init_carry = bus.in_cin;
`endif
    end

    add_mw_sequencer_add8 u_add8 (
        .a         (a_byte),
        .b         (b_byte),
        .carry_in  (carry),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Sequencer FSM: latch request, walk the bytes through the adder, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.in_a;
                        b_r    <= bus.in_b;
                        carry  <= init_carry;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
`ifdef ADD_SEQ_SUB_EN
                        sub_r  <= bus.in_sub;
`endif
                    end
                end
                ST_RUN: begin
                    sum_r[idx] <= add_sum;
                    carry      <= add_cout;
                    if (idx == LAST_IDX) begin
                        // Last byte: its carry-out is the operation's carry/borrow_n.
                        cout_r  <= add_cout;
                        valid_r <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
